mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Multi-port memory arbiter: grants one requester at a time (fixed priority or
// round-robin), forwards its transaction downstream and returns a completion pulse.
module mem_port_arbiter #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ARB_MODE  = 0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          port_request,
  input  logic [NUM_PORTS-1:0]          port_we_re,
  input  logic [NUM_PORTS*DATA_W/8-1:0] port_mask,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_wdata,
  output logic [NUM_PORTS-1:0]          port_valid,
  output logic [NUM_PORTS-1:0]          port_err,
  output logic [DATA_W-1:0]             port_rdata,
  output logic                          mem_request,
  output logic                          mem_we_re,
  output logic [DATA_W/8-1:0]           mem_mask,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_valid,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int unsigned MW = DATA_W / 8;
  localparam int unsigned GW = $clog2(NUM_PORTS);
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TimeoutLast = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic                 we_re_q, we_re_d;
  logic [MW-1:0]        mask_q, mask_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [GW-1:0]        grant_sel;
  logic                 found;
  int unsigned          idx;
  logic [NUM_PORTS-1:0] grant_oh;

  // Search order starts at port 0 (fixed) or just past the previous winner (round-robin).
  always_comb begin
    found     = 1'b0;
    grant_sel = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (ARB_MODE == 1) idx = (32'(last_grant_q) + 1 + i) % NUM_PORTS;
      else               idx = i;
      if (!found && port_request[idx]) begin
        found     = 1'b1;
        grant_sel = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_re_d      = we_re_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|port_request) begin
          state_d      = StBusy;
          grant_d      = grant_sel;
          last_grant_d = grant_sel;
          we_re_d      = port_we_re[grant_sel];
          mask_d       = port_mask[grant_sel*MW +: MW];
          addr_d       = port_addr[grant_sel*ADDR_W +: ADDR_W];
          wdata_d      = port_wdata[grant_sel*DATA_W +: DATA_W];
          cnt_d        = '0;
          err_d        = 1'b0;
        end
      end
      StBusy: begin
        // A completion on the timeout cycle takes precedence over the error.
        if (mem_valid) begin
          state_d = StResp;
          rdata_d = mem_rdata;
          err_d   = 1'b0;
        end else if ((TIMEOUT != 0) && (cnt_q == TimeoutLast)) begin
          state_d = StResp;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_PORTS - 1);
      we_re_q      <= 1'b0;
      mask_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_re_q      <= we_re_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign grant_oh    = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_q;
  assign port_valid  = (state_q == StResp) ? grant_oh : '0;
  assign port_err    = ((state_q == StResp) && err_q) ? grant_oh : '0;
  assign port_rdata  = (state_q == StResp) ? rdata_q : '0;
  assign mem_request = (state_q == StBusy);
  assign mem_we_re   = we_re_q;
  assign mem_mask    = mask_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

endmodule
